// File: rtl/starflux_pkg.sv
// Shared playfield geometry, colours and bullet state encodings for the
// starflux game pipeline (game controller, grid builder, display stage).
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int USER_Y   = 1;
    localparam int ENEMY_Y  = 2;

    localparam logic [2:0] COLOUR_BG     = 3'b000;
    localparam logic [2:0] COLOUR_USER   = 3'b010;
    localparam logic [2:0] COLOUR_ENEMY  = 3'b100;
    localparam logic [2:0] COLOUR_BULLET = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        HIT  = 2'd2
    } bullet_state_e;

endpackage

// File: rtl/tick_gen.sv
// Frame strobe generator: a free-running 0..DIV-1 counter whose last count
// produces a one-clock tick.
module tick_gen #(
    parameter int DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/game_controller.sv
// Game-state stage: player and enemy ship positions, a single bullet, hit
// detection and saturating score, all advanced by the frame strobe.
module game_controller
    import starflux_pkg::*;
#(
    parameter int TICK_DIV      = 833333,
    parameter int BULLET_DIV    = 2,
    parameter int ENEMY_START_X = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_fire,
    output logic [7:0] user_x,
    output logic [7:0] enemy_x,
    output logic [7:0] bullet_x,
    output logic [6:0] bullet_y,
    output logic       bullet_valid,
    output logic       hit,
    output logic [7:0] score
);

    localparam logic [7:0] X_MAX    = 8'(SCREEN_W - 1);
    localparam logic [7:0] X_CENTER = 8'(SCREEN_W / 2);
    localparam logic [7:0] X_START  = 8'(ENEMY_START_X);
    localparam logic [6:0] Y_MAX    = 7'(SCREEN_H - 1);
    localparam logic [6:0] Y_USER   = 7'(USER_Y);
    localparam logic [6:0] Y_ENEMY  = 7'(ENEMY_Y);
    localparam int         SW       = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(BULLET_DIV - 1);

    logic          tick;
    logic          fire_req;
    logic          fire_q;
    logic [7:0]    user_q,  user_d;
    logic [7:0]    enemy_q, enemy_d;
    logic [7:0]    enemy_move;
    logic          dir_q,   dir_d;
    bullet_state_e state_q, state_d;
    logic [SW-1:0] step_q,  step_d;
    logic [7:0]    bx_q,    bx_d;
    logic [6:0]    by_q,    by_d;
    logic [6:0]    by_step;
    logic          valid_q, valid_d;
    logic [7:0]    score_q, score_d;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign fire_req = key_fire & ~fire_q;
    assign by_step  = by_q + 7'd1;

    // Ship motion; dir_q=1 means moving right, bounces hold x for one tick.
    always_comb begin
        user_d     = user_q;
        enemy_move = enemy_q;
        dir_d      = dir_q;
        if (tick) begin
            if (key_left && !key_right && user_q != 8'd0) begin
                user_d = user_q - 8'd1;
            end else if (key_right && !key_left && user_q != X_MAX) begin
                user_d = user_q + 8'd1;
            end
            if (dir_q) begin
                if (enemy_q == X_MAX) dir_d = 1'b0;
                else                  enemy_move = enemy_q + 8'd1;
            end else begin
                if (enemy_q == 8'd0)  dir_d = 1'b1;
                else                  enemy_move = enemy_q - 8'd1;
            end
        end
    end

    // Bullet FSM; the hit test uses the enemy position after this tick's move.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        bx_d    = bx_q;
        by_d    = by_q;
        valid_d = valid_q;
        score_d = score_q;
        enemy_d = enemy_move;
        case (state_q)
            IDLE: begin
                if (fire_req) begin
                    bx_d    = user_q;
                    by_d    = Y_USER;
                    step_d  = '0;
                    valid_d = 1'b1;
                    state_d = FLY;
                end
            end
            FLY: begin
                if (tick) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (by_q == Y_MAX) begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            by_d = by_step;
                            if (by_step == Y_ENEMY && bx_q == enemy_move) begin
                                state_d = HIT;
                            end
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            HIT: begin
                if (score_q != 8'hFF) score_d = score_q + 8'd1;
                enemy_d = X_START;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_q  <= 1'b0;
            user_q  <= X_CENTER;
            enemy_q <= X_START;
            dir_q   <= 1'b1;
            state_q <= IDLE;
            step_q  <= '0;
            bx_q    <= 8'd0;
            by_q    <= 7'd0;
            valid_q <= 1'b0;
            score_q <= 8'd0;
        end else begin
            fire_q  <= key_fire;
            user_q  <= user_d;
            enemy_q <= enemy_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            step_q  <= step_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            valid_q <= valid_d;
            score_q <= score_d;
        end
    end

    assign user_x       = user_q;
    assign enemy_x      = enemy_q;
    assign bullet_x     = bx_q;
    assign bullet_y     = by_q;
    assign bullet_valid = valid_q;
    assign hit          = (state_q == HIT);
    assign score        = score_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a behavioural game model feeds a per-cycle
// scoreboard, with a table of movement phases and scripted shot sequences.
module tb_game_controller;

    localparam int TD    = 4;
    localparam int BD    = 1;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int UY    = 1;
    localparam int EY    = 2;
    localparam int START = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_fire = 1'b0;
    logic [7:0] user_x;
    logic [7:0] enemy_x;
    logic [7:0] bullet_x;
    logic [6:0] bullet_y;
    logic       bullet_valid;
    logic       hit;
    logic [7:0] score;

    game_controller #(
        .TICK_DIV      (TD),
        .BULLET_DIV    (BD),
        .ENEMY_START_X (START)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_fire     (key_fire),
        .user_x       (user_x),
        .enemy_x      (enemy_x),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_valid (bullet_valid),
        .hit          (hit),
        .score        (score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ux;
        logic [7:0] ex;
        logic [7:0] bx;
        logic [6:0] by;
        logic       bv;
        logic       ht;
        logic [7:0] sc;
    } outs_t;

    typedef struct {
        logic l;
        logic r;
        int   ticks;
        int   expUser;
        int   expEnemy;
    } vec_t;

    outs_t sbq[$];
    vec_t  vecs[11];

    int checks = 0;
    int failures = 0;

    int mUser, mEnemy, mDir, mCnt, mSt, mStep, mBx, mBy, mScore;
    bit mFireQ, mValid;

    int hitsSeen = 0;
    int shots = 0;
    int maxY = 0;
    bit prevHit = 1'b0;
    bit prevValid = 1'b0;

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic modelReset();
        mUser  = W / 2;
        mEnemy = START;
        mDir   = 1;
        mCnt   = 0;
        mSt    = 0;
        mStep  = 0;
        mBx    = 0;
        mBy    = 0;
        mScore = 0;
        mFireQ = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic modelStep(input logic l, input logic r, input logic f);
        bit tk;
        bit freq;
        int oldUser;
        int ne;
        int nd;
        tk      = (mCnt == TD - 1);
        freq    = f && !mFireQ;
        oldUser = mUser;
        ne      = mEnemy;
        nd      = mDir;
        mFireQ  = f;
        mCnt    = tk ? 0 : mCnt + 1;
        if (tk) begin
            if (l && !r)      mUser = (mUser > 0) ? mUser - 1 : 0;
            else if (r && !l) mUser = (mUser < W - 1) ? mUser + 1 : W - 1;
            if (mDir == 1 && mEnemy == W - 1)  nd = -1;
            else if (mDir == -1 && mEnemy == 0) nd = 1;
            else ne = mEnemy + mDir;
        end
        case (mSt)
            0: if (freq) begin
                mBx = oldUser; mBy = UY; mStep = 0; mValid = 1'b1; mSt = 1;
            end
            1: if (tk) begin
                if (mStep == BD - 1) begin
                    mStep = 0;
                    if (mBy == H - 1) begin
                        mValid = 1'b0; mSt = 0;
                    end else begin
                        mBy = mBy + 1;
                        if (mBy == EY && mBx == ne) mSt = 2;
                    end
                end else begin
                    mStep = mStep + 1;
                end
            end
            default: begin
                if (mScore < 255) mScore = mScore + 1;
                ne = START; mValid = 1'b0; mSt = 0;
            end
        endcase
        mEnemy = ne;
        mDir   = nd;
    endtask

    function automatic outs_t modelOuts();
        outs_t o;
        o.ux = 8'(mUser);
        o.ex = 8'(mEnemy);
        o.bx = mValid ? 8'(mBx) : 8'd0;
        o.by = mValid ? 7'(mBy) : 7'd0;
        o.bv = mValid;
        o.ht = (mSt == 2);
        o.sc = 8'(mScore);
        return o;
    endfunction

    function automatic outs_t dutOuts();
        outs_t o;
        o.ux = user_x;
        o.ex = enemy_x;
        o.bx = bullet_valid ? bullet_x : 8'd0;
        o.by = bullet_valid ? bullet_y : 7'd0;
        o.bv = bullet_valid;
        o.ht = hit;
        o.sc = score;
        return o;
    endfunction

    // One clock: drive keys, advance the model at the edge, compare just after.
    task automatic applyStimulus(input logic l, input logic r, input logic f);
        outs_t e;
        outs_t g;
        key_left  = l;
        key_right = r;
        key_fire  = f;
        @(posedge clk);
        if (!reset) modelReset();
        else        modelStep(l, r, f);
        sbq.push_back(modelOuts());
        #1;
        e = sbq.pop_front();
        g = dutOuts();
        checks++;
        if (g !== e) begin
            failures++;
            $display("[TB] FAIL scoreboard t=%0t got ux=%0d ex=%0d bx=%0d by=%0d bv=%0b hit=%0b sc=%0d expected ux=%0d ex=%0d bx=%0d by=%0d bv=%0b hit=%0b sc=%0d",
                     $time, g.ux, g.ex, g.bx, g.by, g.bv, g.ht, g.sc,
                     e.ux, e.ex, e.bx, e.by, e.bv, e.ht, e.sc);
        end
        if (hit === 1'b1) begin
            checkOutput("hit_width", int'(prevHit), 0);
            hitsSeen++;
        end
        if (bullet_valid === 1'b1 && !prevValid) shots++;
        if (bullet_valid === 1'b1 && int'(bullet_y) > maxY) maxY = int'(bullet_y);
        prevHit   = (hit === 1'b1);
        prevValid = (bullet_valid === 1'b1);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic doReset();
        key_left  = 1'b0;
        key_right = 1'b0;
        key_fire  = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_user_x", int'(user_x), W / 2);
        checkOutput("rst_enemy_x", int'(enemy_x), START);
        checkOutput("rst_score", int'(score), 0);
        checkOutput("rst_valid", int'(bullet_valid), 0);
        checkOutput("rst_hit", int'(hit), 0);
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic l, r, f;
        bit pendingPost;

        vecs[0]  = '{1'b1, 1'b0, 79,  1,   159};
        vecs[1]  = '{1'b1, 1'b0, 1,   0,   159};
        vecs[2]  = '{1'b1, 1'b0, 1,   0,   158};
        vecs[3]  = '{1'b1, 1'b0, 19,  0,   139};
        vecs[4]  = '{1'b1, 1'b1, 10,  0,   129};
        vecs[5]  = '{1'b0, 1'b1, 5,   5,   124};
        vecs[6]  = '{1'b0, 1'b0, 124, 5,   0};
        vecs[7]  = '{1'b0, 1'b0, 1,   5,   0};
        vecs[8]  = '{1'b0, 1'b0, 1,   5,   1};
        vecs[9]  = '{1'b0, 1'b1, 200, 159, 118};
        vecs[10] = '{1'b1, 1'b1, 3,   159, 115};

        doReset();

        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < vecs[i].ticks * TD; c++) begin
                applyStimulus(vecs[i].l, vecs[i].r, 1'b0);
            end
            checkOutput($sformatf("vec%0d_user_x", i), int'(user_x), vecs[i].expUser);
            checkOutput($sformatf("vec%0d_enemy_x", i), int'(enemy_x), vecs[i].expEnemy);
            checkOutput($sformatf("vec%0d_valid", i), int'(bullet_valid), 0);
        end

        // Miss: bullet from x=159 while the enemy is far left, with a retry mid-flight.
        shots = 0; hitsSeen = 0; maxY = 0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("miss_launch_valid", int'(bullet_valid), 1);
        checkOutput("miss_launch_y", int'(bullet_y), UY);
        checkOutput("miss_launch_x", int'(bullet_x), 159);
        n = 0;
        while (bullet_valid === 1'b1 && n < 600) begin
            applyStimulus(1'b0, 1'b0, (n == 80));
            n++;
        end
        checkOutput("miss_landed", int'(bullet_valid), 0);
        checkOutput("miss_top_row", maxY, H - 1);
        checkOutput("miss_hits", hitsSeen, 0);
        checkOutput("miss_shots", shots, 1);
        checkOutput("miss_score", int'(score), 0);

        // Fire key held for 50 ticks yields a single shot.
        shots = 0;
        for (int c = 0; c < 50 * TD; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        while (bullet_valid === 1'b1 && n < 600) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("held_landed", int'(bullet_valid), 0);
        checkOutput("held_shots", shots, 1);

        // Lined-up shots: player parks at START+1 and fires as the enemy leaves START.
        doReset();
        hitsSeen = 0; pendingPost = 1'b0; n = 0;
        while ((hitsSeen < 256 || pendingPost) && n < 6000) begin
            l = (mUser > START + 1);
            r = (mUser < START + 1);
            f = !key_fire && mSt == 0 && mCnt != TD - 1 && mEnemy == START &&
                mDir == 1 && mUser == START + 1;
            applyStimulus(l, r, f);
            if (pendingPost) begin
                checkOutput("post_hit_pulse", int'(hit), 0);
                checkOutput("post_hit_enemy_x", int'(enemy_x), START);
                checkOutput("post_hit_valid", int'(bullet_valid), 0);
                checkOutput("post_hit_score", int'(score), (hitsSeen > 255) ? 255 : hitsSeen);
                pendingPost = 1'b0;
            end
            if (hit === 1'b1) begin
                checkOutput("hit_row", int'(bullet_y), EY);
                checkOutput("hit_col", int'(bullet_x), START + 1);
                pendingPost = 1'b1;
            end
            n++;
        end
        checkOutput("hits_total", hitsSeen, 256);
        checkOutput("score_saturated", int'(score), 255);

        // Reset in the middle of a flight with score at 255.
        n = 0;
        while (bullet_valid !== 1'b1 && n < 16) begin
            f = !key_fire && mSt == 0 && mCnt != TD - 1 && mEnemy == START &&
                mDir == 1 && mUser == START + 1;
            applyStimulus(1'b0, 1'b0, f);
            n++;
        end
        checkOutput("pre_reset_valid", int'(bullet_valid), 1);
        doReset();
        for (int c = 0; c < 3 * TD; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("final_score", int'(score), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
